// File: rtl/i2c_write_master_if.sv
// Request/status handshake and I2C pin bundle
// between the config sequencer and the write master.
interface i2c_write_master_if;
  logic       ack_i2c;
  logic       wr_rd;
  logic [6:0] addr;
  logic [7:0] addr_reg;
  logic [7:0] data_config;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl;
  logic       sda_oe;
  logic       sda_i;

  modport master (
    input  ack_i2c,
    input  wr_rd,
    input  addr,
    input  addr_reg,
    input  data_config,
    input  sda_i,
    output busy,
    output done,
    output nack,
    output scl,
    output sda_oe
  );

  modport slave (
    output ack_i2c,
    output wr_rd,
    output addr,
    output addr_reg,
    output data_config,
    output sda_i,
    input  busy,
    input  done,
    input  nack,
    input  scl,
    input  sda_oe
  );
endinterface

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, three bytes
// each followed by an ACK slot, then STOP.
module i2c_write_master #(
  parameter int CLK_DIV = 125
) (
  input logic                clk,
  input logic                reset_n,
  i2c_write_master_if.master m
);
  typedef enum logic [2:0] {
    IDLE, START, BIT, ACK, STOP, DONE
  } state_t;

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [1:0]  q;
  logic [2:0]  bitn;
  logic [1:0]  idx;
  logic [7:0]  sh;
  logic [7:0]  b1;
  logic [7:0]  b2;
  logic        ack_bit;
  logic        busy_r;
  logic        done_r;
  logic        nack_r;
  logic        scl_r;
  logic        oe_r;
  logic        wrap;
  logic [7:0]  nxt;

  assign wrap     = (cnt == LAST);
  assign nxt      = (idx == 2'd0) ? b1 : b2;
  assign m.busy   = busy_r;
  assign m.done   = done_r;
  assign m.nack   = nack_r;
  assign m.scl    = scl_r;
  assign m.sda_oe = oe_r;

  // Line levels are loaded at each quarter wrap
  // with the values of the quarter being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      q       <= '0;
      bitn    <= '0;
      idx     <= '0;
      sh      <= '0;
      b1      <= '0;
      b2      <= '0;
      ack_bit <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      nack_r  <= 1'b0;
      scl_r   <= 1'b1;
      oe_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (state inside {START, BIT, ACK, STOP})
        cnt <= wrap ? '0 : cnt + 16'd1;
      unique case (state)
        IDLE: if (m.ack_i2c) begin
          sh      <= {m.addr, m.wr_rd};
          b1      <= m.addr_reg;
          b2      <= m.data_config;
          nack_r  <= 1'b0;
          busy_r  <= 1'b1;
          cnt     <= '0;
          q       <= '0;
          bitn    <= 3'd7;
          idx     <= '0;
          ack_bit <= 1'b0;
          state   <= START;
        end
        START: if (wrap) begin
          if (q == 2'd0) begin
            q    <= 2'd1;
            oe_r <= 1'b1;
          end else begin
            q     <= 2'd0;
            scl_r <= 1'b0;
            oe_r  <= ~sh[7];
            state <= BIT;
          end
        end
        BIT: if (wrap) begin
          q <= q + 2'd1;
          unique case (q)
            2'd0: scl_r <= 1'b1;
            2'd2: scl_r <= 1'b0;
            2'd3: begin
              if (bitn == 3'd0) begin
                oe_r  <= 1'b0;
                state <= ACK;
              end else begin
                bitn <= bitn - 3'd1;
                sh   <= {sh[6:0], 1'b0};
                oe_r <= ~sh[6];
              end
            end
            default: ;
          endcase
        end
        ACK: if (wrap) begin
          q <= q + 2'd1;
          unique case (q)
            2'd0: scl_r <= 1'b1;
            2'd2: begin
              scl_r   <= 1'b0;
              ack_bit <= m.sda_i;
            end
            2'd3: begin
              if (ack_bit || idx == 2'd2) begin
                if (ack_bit) nack_r <= 1'b1;
                oe_r  <= 1'b1;
                state <= STOP;
              end else begin
                idx   <= idx + 2'd1;
                sh    <= nxt;
                bitn  <= 3'd7;
                oe_r  <= ~nxt[7];
                state <= BIT;
              end
            end
            default: ;
          endcase
        end
        STOP: if (wrap) begin
          q <= q + 2'd1;
          unique case (q)
            2'd0: scl_r <= 1'b1;
            2'd1: oe_r <= 1'b0;
            default: begin
              q      <= 2'd0;
              busy_r <= 1'b0;
              done_r <= 1'b1;
              state  <= DONE;
            end
          endcase
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus decode,
// busy/done timing, NACK, reset, SCL rates.
module tb_i2c_write_master;
  typedef struct {
    logic [2:0][7:0] b;
    int              nk;
  } frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_write_master_if bus ();
  i2c_write_master_if bus2 ();
  i2c_write_master_if bus3 ();

  logic pull = 1'b0;
  assign bus.sda_i  = ~(bus.sda_oe | pull);
  assign bus2.sda_i = ~bus2.sda_oe;
  assign bus3.sda_i = ~bus3.sda_oe;

  assign bus2.wr_rd       = bus.wr_rd;
  assign bus2.addr        = bus.addr;
  assign bus2.addr_reg    = bus.addr_reg;
  assign bus2.data_config = bus.data_config;
  assign bus3.wr_rd       = bus.wr_rd;
  assign bus3.addr        = bus.addr;
  assign bus3.addr_reg    = bus.addr_reg;
  assign bus3.data_config = bus.data_config;

  i2c_write_master #(.CLK_DIV(4)) dut (
    .clk(clk), .reset_n(rst_n), .m(bus.master));
  i2c_write_master #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset_n(rst_n), .m(bus2.master));
  i2c_write_master #(.CLK_DIV(125)) dut3 (
    .clk(clk), .reset_n(rst_n), .m(bus3.master));

  logic [2:0] v_scl, v_sda, v_busy, v_done;
  assign v_scl  = {bus3.scl, bus2.scl, bus.scl};
  assign v_sda  = {bus3.sda_i, bus2.sda_i, bus.sda_i};
  assign v_busy = {bus3.busy, bus2.busy, bus.busy};
  assign v_done = {bus3.done, bus2.done, bus.done};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  int div [3] = '{4, 2, 125};
  int cyc = 0;
  int blen [3];
  int last_rise [3];
  int pmin [3];
  int pmax [3];
  int hichg [3];
  int ndone [3] = '{0, 0, 0};
  int nfr [3] = '{0, 0, 0};
  int qexp [3][$];
  frame_t fq [$];
  logic [2:0] p_scl, p_sda, p_busy;
  int bitpos = 0;
  int nbyte = 0;
  logic [7:0] cur = 8'h00;
  logic in_frame = 1'b0;
  logic [7:0] got [$];

  always @(negedge clk) begin : mon
    logic [2:0] s_scl, s_sda, s_busy;
    frame_t f;
    int n, per;
    s_scl  = v_scl;
    s_sda  = v_sda;
    s_busy = v_busy;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        blen[i] = 0;
        last_rise[i] = -1;
        pmin[i] = 1 << 30;
        pmax[i] = 0;
        hichg[i] = 0;
        qexp[i].delete();
      end
      fq.delete();
      got.delete();
      in_frame = 1'b0;
      pull = 1'b0;
      bitpos = 0;
      nbyte = 0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s_busy[i]) blen[i]++;
        if (v_done[i]) ndone[i]++;
        if (s_scl[i] && !p_scl[i]) begin
          if (last_rise[i] >= 0) begin
            per = cyc - last_rise[i];
            if (per < pmin[i]) pmin[i] = per;
            if (per > pmax[i]) pmax[i] = per;
          end
          last_rise[i] = cyc;
        end
        if (s_scl[i] && p_scl[i] &&
            s_sda[i] != p_sda[i])
          hichg[i]++;
        if (!s_busy[i] && p_busy[i]) begin
          chk("done_at_busy_fall", v_done[i], 1);
          chk("frame_expected", qexp[i].size(), 1);
          if (qexp[i].size() > 0)
            chk("busy_len", blen[i],
                qexp[i].pop_front() * div[i]);
          chk("scl_per_min", pmin[i], 4 * div[i]);
          chk("scl_per_max", pmax[i], 4 * div[i]);
          chk("sda_hi_changes", hichg[i], 2);
          blen[i] = 0;
          last_rise[i] = -1;
          pmin[i] = 1 << 30;
          pmax[i] = 0;
          hichg[i] = 0;
        end
      end
      // main-bus protocol decode and slave model
      if (p_scl[0] && s_scl[0] &&
          p_sda[0] && !s_sda[0]) begin
        chk("start_idle", in_frame, 0);
        in_frame = 1'b1;
        bitpos = 0;
        nbyte = 0;
        got.delete();
      end else if (in_frame && p_scl[0] &&
                   s_scl[0] && !p_sda[0] &&
                   s_sda[0]) begin
        in_frame = 1'b0;
        pull = 1'b0;
        chk("stop_pos", bitpos, 1);
        chk("frame_known", fq.size() > 0, 1);
        if (fq.size() > 0) begin
          f = fq.pop_front();
          n = (f.nk < 3) ? f.nk + 1 : 3;
          chk("nbytes", got.size(), n);
          for (int k = 0; k < n; k++)
            if (k < got.size())
              chk($sformatf("byte%0d", k),
                  got[k], f.b[k]);
        end
      end else if (in_frame && s_scl[0] &&
                   !p_scl[0]) begin
        if (bitpos < 8) begin
          cur = {cur[6:0], s_sda[0]};
          bitpos++;
          if (bitpos == 8) got.push_back(cur);
        end else begin
          chk("ack_slot", s_sda[0],
              fq.size() > 0 && fq[0].nk == nbyte);
          nbyte++;
          bitpos = 0;
        end
      end else if (in_frame && !s_scl[0] &&
                   p_scl[0]) begin
        pull = (bitpos == 8 && fq.size() > 0 &&
                fq[0].nk != nbyte);
      end
    end
    p_scl  = s_scl;
    p_sda  = s_sda;
    p_busy = s_busy;
  end

  task automatic run_frame(
    input logic [6:0] a, input logic rw,
    input logic [7:0] r, input logic [7:0] d,
    input int nk, input int hold, input bit noise);
    frame_t f;
    int n;
    f.b[0] = {a, rw};
    f.b[1] = r;
    f.b[2] = d;
    f.nk = nk;
    fq.push_back(f);
    qexp[0].push_back(nk < 3 ? 5 + 36 * (nk + 1)
                             : 113);
    nfr[0]++;
    chk("idle_busy", bus.busy, 0);
    bus.addr = a;
    bus.wr_rd = rw;
    bus.addr_reg = r;
    bus.data_config = d;
    bus.ack_i2c = 1'b1;
    @(negedge clk);
    chk("busy_next", bus.busy, 1);
    chk("nack_clr", bus.nack, 0);
    repeat (hold - 1) @(negedge clk);
    bus.ack_i2c = 1'b0;
    if (noise) begin
      repeat (30) begin
        bus.addr = 7'($urandom);
        bus.wr_rd = 1'($urandom);
        bus.addr_reg = 8'($urandom);
        bus.data_config = 8'($urandom);
        bus.ack_i2c = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      bus.ack_i2c = 1'b0;
    end
    n = 0;
    while (!bus.done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", bus.done, 1);
    @(negedge clk);
    chk("done_pulse", bus.done, 0);
    chk("nack_flag", bus.nack, nk < 3);
  endtask

  logic [15:0] b2b [3] = '{16'h0579, 16'h0779,
                           16'h13FF};

  initial begin
    int nk, lows, n;
    logic [15:0] w;
    bus.ack_i2c = 1'b0;
    bus.wr_rd = 1'b0;
    bus.addr = '0;
    bus.addr_reg = '0;
    bus.data_config = '0;
    bus2.ack_i2c = 1'b0;
    bus3.ack_i2c = 1'b0;
    @(negedge clk);
    chk("rst_scl", bus.scl, 1);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_nack", bus.nack, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(7'h1A, 1'b0, 8'h1E, 8'h00, 3, 2, 0);
    run_frame(7'h1A, 1'b0, 8'h1E, 8'h00, 0, 2, 0);
    run_frame(7'h1A, 1'b0, 8'h0A, 8'hC3, 3, 1, 1);
    for (int i = 0; i < 10; i++) begin
      w = b2b[i % 3];
      run_frame(7'h1A, 1'b0, w[15:8], w[7:0],
                3, 2, 0);
    end
    for (int i = 0; i < 6; i++) begin
      nk = int'($urandom_range(0, 4));
      if (nk > 3) nk = 3;
      run_frame(7'($urandom), 1'($urandom),
                8'($urandom), 8'($urandom), nk,
                int'($urandom_range(1, 3)), 0);
    end

    bus.addr = 7'h55;
    bus.addr_reg = 8'hA5;
    bus.data_config = 8'h5A;
    bus.ack_i2c = 1'b1;
    @(negedge clk);
    bus.ack_i2c = 1'b0;
    repeat (27) @(negedge clk);
    chk("busy_pre_rst", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_scl", bus.scl, 1);
    chk("arst_sda_oe", bus.sda_oe, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_nack", bus.nack, 0);
    lows = 0;
    repeat (5) begin
      @(negedge clk);
      if (!bus.scl) lows++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!bus.scl || bus.busy) lows++;
    end
    chk("quiet_after_rst", lows, 0);

    qexp[1].push_back(41);
    qexp[2].push_back(41);
    nfr[1]++;
    nfr[2]++;
    bus.addr = 7'h1A;
    bus.wr_rd = 1'b0;
    bus.addr_reg = 8'h1E;
    bus.data_config = 8'h00;
    bus2.ack_i2c = 1'b1;
    bus3.ack_i2c = 1'b1;
    @(negedge clk);
    bus2.ack_i2c = 1'b0;
    bus3.ack_i2c = 1'b0;
    n = 0;
    while (!bus3.done && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk("slow_done", bus3.done, 1);
    @(negedge clk);
    chk("nack_div2", bus2.nack, 1);
    chk("nack_div125", bus3.nack, 1);

    for (int i = 0; i < 3; i++)
      chk($sformatf("done_count%0d", i),
          ndone[i], nfr[i]);
    chk("frames_left", fq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_write_master.md
Name: i2c_write_master

Overview:
- Single-master, write-only I2C engine directly downstream of the codec configuration sequencer.
- On a start request it latches the 7-bit device address, R/W bit, register byte and data byte, then emits one 3-byte I2C frame on SCL/SDA: START, {addr,wr_rd}, ACK, addr_reg, ACK, data, ACK, STOP.
- Reports progress to the sequencer through `busy`. Reports completion and slave acknowledge status through `done` and `nack`.

Parameters:
- CLK_DIV, 125: clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV (50 MHz -> 100 kHz). Legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- ack_i2c  input  1  start request; sampled only in IDLE; may be held high for several cycles
- wr_rd  input  1  R/W bit; transmitted verbatim as bit 0 of byte 0; sequencer ties it to 0
- addr  input  7  slave device address (0x1A for codec)
- addr_reg  input  8  second byte (codec register byte)
- data_config  input  8  third byte
- busy  output  1  high from the cycle after start acceptance until frame end
- done  output  1  one-cycle pulse on the cycle busy falls
- nack  output  1  sticky: last frame saw a NACK; cleared on next start acceptance
- scl  output  1  SCL level (1 = released/high)
- sda_oe  output  1  1 = pull SDA low, 0 = release
- sda_i  input  1  SDA pad level, already synchronised externally

Behaviour:
- Reset (async, reset_n low):
  - Outputs: scl=1, sda_oe=0, busy=0, done=0, nack=0.
  - State IDLE, all counters 0.
  - Reset mid-frame releases both lines immediately. No STOP is generated.
- Clocking:
  - Quarter counter counts 0..CLK_DIV-1.
  - The phase advances when the counter wraps.
  - scl and sda_oe are registered and change only on phase boundaries.
- Start acceptance:
  - In IDLE with ack_i2c=1 at a clk edge, latch shift_reg0={addr,wr_rd}, addr_reg, data_config.
  - On the same edge, clear nack and go to START. busy=1 from the next cycle.
  - ack_i2c is ignored in all other states, so extra request cycles (the sequencer holds it 2 cycles) have no effect.
- States:
  - IDLE: scl=1, sda_oe=0.
  - START: 2 quarters, (scl1,sda released) then (scl1,sda low).
  - BIT: 8 bits per byte, MSB first, 4 quarters per bit:
    - q0: scl0, SDA set to bit (sda_oe=~bit).
    - q1: scl1.
    - q2: scl1.
    - q3: scl0.
  - ACK: 4 quarters with sda_oe=0. sda_i is sampled on the last clk of q2; 1 = NACK.
  - STOP: 3 quarters, (scl0,sda low), (scl1,sda low), (scl1,sda released).
  - DONE: 1 cycle. Asserts done, busy=0 on that same cycle, then IDLE.
- Byte sequencing:
  - Byte index 0..2 and bit counter 7..0.
  - After ACK: if NACK, set nack=1 and go to STOP, skipping remaining bytes.
  - Else if byte index is 2, go to STOP. Else go to BIT with the next byte.
- Latency:
  - Full ACKed frame = 2 + 27*4 + 3 = 113 quarters = 113*CLK_DIV cycles of busy=1.
  - done fires on the cycle busy first reads 0.
- IDLE re-entry: ack_i2c high in the cycle after DONE starts a new frame; back-to-back frames are legal.
- SDA changes only while scl=0, except the START and STOP edges.

Test Plan:
- Reset during idle and mid-BIT (CLK_DIV=4) -> scl=1, sda_oe=0, busy=0, done=0, nack=0 asynchronously; no further SCL edges.
- addr=0x1A, wr_rd=0, addr_reg=0x1E, data_config=0x00, ack_i2c held 2 cycles, slave ACKs all (CLK_DIV=4):
  - bus monitor decodes START, 0x34, ACK, 0x1E, ACK, 0x00, ACK, STOP.
  - busy high for exactly 452 cycles starting the cycle after ack_i2c rose; done pulses once; nack=0.
- Same frame but slave NACKs byte 0 -> STOP directly after first ACK slot; busy high 2+9*4+3=41 quarters; nack=1 until next start, then cleared.
- ack_i2c pulsed repeatedly while busy -> ignored; exactly one frame emitted; latched bytes unchanged even if inputs change mid-frame.
- Ten back-to-back frames with data 0x0579, 0x0779, 0x13FF (sequencer-style handshake, request one cycle after done) -> all ten frames decoded correctly.
- CLK_DIV=2 and CLK_DIV=125 -> SCL period 8 and 500 cycles; SDA stable whenever scl=1 except START/STOP edges (assertion).
